// File: rtl/display_pkg.sv
// Constants shared by the display scanner and the 7-segment decoder it feeds.
package display_pkg;
  // Must match the decoder's default branch, which turns all segments off.
  localparam logic [7:0] CODIGO_APAGADO = 8'hFF;
  localparam int DIV_PADRAO     = 50000;
  localparam int NUM_DIG_PADRAO = 8;
endpackage

// File: rtl/divisor_freq.sv
// Digit-slot prescaler: counts 0..DIV-1 and flags the last count with tick.
module divisor_freq
  import display_pkg::*;
#(
  parameter int DIV = DIV_PADRAO
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  // One bit minimum so DIV=1 still has a (constant zero) counter.
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] MAX = W'(DIV - 1);

  logic [W-1:0] cont;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont <= '0;
    end else if (cont == MAX) begin
      cont <= '0;
    end else begin
      cont <= cont + 1'b1;
    end
  end

  assign tick = (cont == MAX);

endmodule

// File: rtl/varredor_display.sv
// Time-multiplexed hex display scanner with double-buffered loads that commit
// only at frame boundaries, plus optional leading-zero blanking.
module varredor_display
  import display_pkg::*;
#(
  parameter int NUM_DIG = NUM_DIG_PADRAO,
  parameter int DIV     = DIV_PADRAO,
  localparam int IW     = $clog2(NUM_DIG)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4*NUM_DIG-1:0]   valor,
  input  logic                   carga,
  input  logic                   apagar_zeros,
  output logic [7:0]             digito,
  output logic [NUM_DIG-1:0]     anodo,
  output logic [IW-1:0]          indice,
  output logic                   pendente
);

  // Handshake: carga is a strobe with no ready; every edge where it is high
  // overwrites buffer with valor and raises pendente, and ativo only takes
  // buffer on the last tick of a frame, so a frame is never torn.

  localparam logic [IW-1:0] ULTIMO = IW'(NUM_DIG - 1);

  logic                 tick;
  logic                 commit;
  logic [4*NUM_DIG-1:0] buffer;
  logic [4*NUM_DIG-1:0] ativo;
  logic [NUM_DIG-1:0]   zeros_acima;
  logic                 zero_acc;
  logic [3:0]           nibble;
  logic                 blanked;

  divisor_freq #(.DIV(DIV)) u_divisor (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign commit = tick && (indice == ULTIMO) && pendente;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      indice <= '0;
    end else if (tick) begin
      indice <= (indice == ULTIMO) ? '0 : indice + 1'b1;
    end
  end

  // On a simultaneous load and commit, ativo takes the old buffer and the
  // new value stays pending for the next frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buffer   <= '0;
      ativo    <= '0;
      pendente <= 1'b0;
    end else begin
      if (commit) begin
        ativo <= buffer;
      end
      if (carga) begin
        buffer   <= valor;
        pendente <= 1'b1;
      end else if (commit) begin
        pendente <= 1'b0;
      end
    end
  end

  // zeros_acima[i] is set when nibbles NUM_DIG-1..i of ativo are all zero.
  always_comb begin
    zero_acc    = 1'b1;
    zeros_acima = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      zero_acc       = zero_acc & (ativo[4*i +: 4] == 4'h0);
      zeros_acima[i] = zero_acc;
    end
    nibble  = ativo[4*indice +: 4];
    blanked = apagar_zeros && (indice != '0) && zeros_acima[indice];
    digito  = blanked ? CODIGO_APAGADO : {4'b0000, nibble};
    anodo   = ~(NUM_DIG'(1) << indice);
  end

endmodule

// File: doc/varredor_display.md
# varredor_display

Time-multiplexed display scanner that sits directly upstream of the 7-segment `decodificador`. It snapshots a multi-digit hex value and walks through its nibbles one digit at a time. Each cycle it presents the current nibble as the decoder's 8-bit `entrada` and drives the matching active-low anode. Optional leading-zero blanking emits code 8'hFF, which the decoder's default branch turns into all segments off.

## Interface
- `NUM_DIG`, 8, number of digits scanned (≥2)
- `DIV`, 50000, clocks per digit slot (≥1)
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `valor`  in  4*NUM_DIG  hex value; nibble i is digit i, digit 0 is least significant
- `carga`  in  1  load strobe; `valor` is sampled on any edge where it is high
- `apagar_zeros`  in  1  enables leading-zero blanking, sampled live
- `digito`  out  8  to decoder `entrada`: {4'b0, nibble} or 8'hFF when blanked
- `anodo`  out  NUM_DIG  one-hot active-low digit enable
- `indice`  out  $clog2(NUM_DIG)  current digit index
- `pendente`  out  1  a loaded value is waiting to be committed

## Operation
- Prescaler `cont` counts 0..DIV-1 and wraps. `tick` = (cont == DIV-1). With DIV=1, `tick` is high every cycle.
- On `tick`, `indice` increments and wraps from NUM_DIG-1 to 0.
- Buffering uses two registers, `buffer` and `ativo`. `carga`=1 writes `valor` into `buffer` and sets `pendente`.
- Commit happens only at a frame boundary: `tick` && `indice`==NUM_DIG-1 && `pendente`. Then `ativo` ← `buffer` and `pendente` clears. This prevents torn frames.
- Simultaneous `carga` and commit on the same edge:
  - `ativo` receives the old `buffer`.
  - `buffer` receives the new `valor`.
  - `pendente` stays 1.
- Blanking applies when `apagar_zeros`=1. Digit i>0 is blanked if nibbles NUM_DIG-1..i of `ativo` are all zero. Digit 0 is never blanked, so an all-zero value shows "0".
- Outputs are pure functions of registered state (`indice`, `ativo`) plus `apagar_zeros`:
  - `anodo` = ~(1 << `indice`)
  - `digito` = blanked ? 8'hFF : {4'b0, `ativo`[4*`indice` +: 4]}
- Reset (asynchronous, `reset`=0):
  - `cont`, `indice`, `buffer`, `ativo` and `pendente` go to 0.
  - Outputs then read `anodo` = all ones except bit 0 low, `digito`=8'h00, `indice`=0, `pendente`=0.
- Reset mid-frame or with a pending load discards both registers. No partial commit.

## Timing
- `indice`, `anodo` and `digito` change on the edge where `tick` is high, and are stable for exactly DIV cycles per digit.
- Frame period = NUM_DIG·DIV cycles.
- Load-to-display latency: from the `carga` edge to the end of the current frame, at most NUM_DIG·DIV cycles. The committed value first appears as digit 0 on the commit edge.
- `pendente` rises on the edge after `carga` and falls on the commit edge.
- A `apagar_zeros` change affects `digito` combinationally in the same cycle, with no registered delay.

## Structure
- Shared package `display_pkg` holds:
  - `CODIGO_APAGADO` = 8'hFF (must match the decoder's default branch)
  - `DIV_PADRAO` = 50000
  - `NUM_DIG_PADRAO` = 8
- One sub-module, `divisor_freq`: parameter DIV, ports `clock`, `reset`, `tick` out. It contains the prescaler only.
- Blanking logic is a combinational loop over digits, implemented inside `varredor_display`.

## Test plan
All scenarios use NUM_DIG=4 and DIV=4.
- Reset release, `carga` never asserted → `digito`=8'h00 and `anodo`=4'b1110 for cycles 0-3. `indice` then steps 1,2,3,0 every 4 cycles.
- `valor`=16'h1A2F with `carga` at cycle 5, `apagar_zeros`=0 → `pendente`=1 until the edge where `indice` wraps 3→0 at cycle 16. From then `digito` sequence per slot is 0F,02,0A,01 with `anodo` 1110,1101,1011,0111.
- `valor`=16'h00B0 committed, `apagar_zeros`=1 → slots show 00, 0B, FF, FF. With `apagar_zeros`=0, slots show 00, 0B, 00, 00. With `valor`=0 and blanking on → 00, FF, FF, FF.
- `carga` with 16'h1111 at cycle 5, then `carga` with 16'h2222 at cycle 15, which coincides with the commit edge:
  - Frame 2 shows 1s and `pendente` stays 1.
  - Frame 3 shows 2s and `pendente` clears at its start.
- `reset` pulsed low at cycle 9 with a pending load → immediate `anodo`=4'b1110, `digito`=00, `pendente`=0. The previous value is never displayed.
- DIV=1 → `indice` advances every cycle and `anodo` rotates each clock.
